// File: rtl/tcb_htif_pkg.sv
// Shared types and constants for the TCB HTIF mailbox controller.
package tcb_htif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HALT = 2'd2
  } htif_state_t;

  localparam logic [7:0] DEV_EXIT = 8'd0;
  localparam logic [7:0] DEV_CON  = 8'd1;
  localparam logic [7:0] CMD_PUTC = 8'd1;

  // byte offsets of the low/high words inside each 64-bit mailbox
  localparam logic [31:0] OFS_LO = 32'd0;
  localparam logic [31:0] OFS_HI = 32'd4;

  localparam logic [1:0]  SIZE_WORD     = 2'd2;
  localparam logic [31:0] FH_CON_ACK_HI = 32'h0101_0000;

endpackage

// File: rtl/tcb_htif_fifo.sv
// Synchronous FIFO for the console byte stream; output is valid the cycle
// after a push (no fall-through) and reads as zero while empty.
module tcb_htif_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // extra MSB on each pointer tells a full ring from an empty one
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/tcb_htif_ctl.sv
// HTIF tohost/fromhost mailbox subordinate on the TCB bus: exit -> sticky halt,
// putchar -> console FIFO, plus a cycle watchdog. Console path needs HTIF_CONSOLE_EN.
module tcb_htif_ctl
  import tcb_htif_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter logic [31:0] ADR_TOHOST   = 32'h8000_1000,
  parameter logic [31:0] ADR_FROMHOST = 32'h8000_1040,
  parameter int unsigned FIFO_DEP     = 8,
  parameter int unsigned TIMEOUT      = 20000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tcb_vld,
  input  logic            tcb_wen,
  input  logic [XLEN-1:0] tcb_adr,
  input  logic [2:0]      tcb_fn3,
  input  logic [XLEN-1:0] tcb_wdt,
  output logic [XLEN-1:0] tcb_rdt,
  output logic            tcb_err,
  output logic            tcb_rdy,
  output logic            halt,
  output logic [30:0]     exit_code,
  output logic            timeout,
  output logic            con_vld,
  output logic [7:0]      con_dat,
  input  logic            con_rdy
);

  localparam logic [31:0] A_TH_LO   = ADR_TOHOST + OFS_LO;
  localparam logic [31:0] A_TH_HI   = ADR_TOHOST + OFS_HI;
  localparam logic [31:0] A_FH_LO   = ADR_FROMHOST + OFS_LO;
  localparam logic [31:0] A_FH_HI   = ADR_FROMHOST + OFS_HI;
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  htif_state_t state_reg, state_next;
  logic [31:0] lo_reg, hi_reg, fh_lo_reg, fh_hi_reg;
  logic [30:0] exit_code_reg;
  logic [31:0] rdt_reg, rd_mux;
  logic        err_reg;
  logic [31:0] wdog_cnt_reg;
  logic        timeout_reg;

  logic hit_th_lo, hit_th_hi, hit_fh_lo, hit_fh_hi;
  logic acc_ok, xfer, wr_ok;
  logic is_exit_cmd, is_con_cmd;
  logic commit_req, con_req, commit;

  assign hit_th_lo = (tcb_adr == A_TH_LO);
  assign hit_th_hi = (tcb_adr == A_TH_HI);
  assign hit_fh_lo = (tcb_adr == A_FH_LO);
  assign hit_fh_hi = (tcb_adr == A_FH_HI);
  assign acc_ok    = (tcb_fn3[1:0] == SIZE_WORD) &
                     (hit_th_lo | hit_th_hi | hit_fh_lo | hit_fh_hi);

  assign is_exit_cmd = (tcb_wdt[31:24] == DEV_EXIT) & lo_reg[0];
  assign is_con_cmd  = (tcb_wdt[31:24] == DEV_CON) & (tcb_wdt[23:16] == CMD_PUTC);

  // commit_req is evaluated before ready so a full FIFO can stall only putchar
  assign commit_req = tcb_vld & tcb_wen & acc_ok & hit_th_hi & (state_reg == ST_LOW);
  assign con_req    = commit_req & is_con_cmd;
  assign xfer       = tcb_vld & tcb_rdy;
  assign wr_ok      = xfer & tcb_wen & acc_ok;
  assign commit     = commit_req & tcb_rdy;

  always_comb begin
    rd_mux = '0;
    if (hit_th_lo)      rd_mux = lo_reg;
    else if (hit_th_hi) rd_mux = hi_reg;
    else if (hit_fh_lo) rd_mux = fh_lo_reg;
    else if (hit_fh_hi) rd_mux = fh_hi_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (wr_ok && hit_th_lo) state_next = ST_LOW;
      ST_LOW:  if (commit) state_next = is_exit_cmd ? ST_HALT : ST_IDLE;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_reg        <= '0;
      hi_reg        <= '0;
      fh_lo_reg     <= '0;
      fh_hi_reg     <= '0;
      exit_code_reg <= '0;
      rdt_reg       <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (wr_ok && hit_th_lo) lo_reg    <= tcb_wdt;
      if (wr_ok && hit_th_hi) hi_reg    <= tcb_wdt;
      if (wr_ok && hit_fh_lo) fh_lo_reg <= tcb_wdt;
      if (wr_ok && hit_fh_hi) fh_hi_reg <= tcb_wdt;
      if (commit && is_con_cmd) begin
        fh_lo_reg <= '0;
        fh_hi_reg <= FH_CON_ACK_HI;
      end
      if (commit && is_exit_cmd) exit_code_reg <= lo_reg[31:1];
      // response registers hold their value between transfers
      if (xfer) begin
        err_reg <= ~acc_ok;
        rdt_reg <= (acc_ok && !tcb_wen) ? rd_mux : '0;
      end
    end
  end

  // counter freezes once expired; with TIMEOUT=0 it just free-runs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else if (!timeout_reg) begin
      wdog_cnt_reg <= wdog_cnt_reg + 32'd1;
      if ((TIMEOUT_W != 32'd0) && (wdog_cnt_reg + 32'd1 == TIMEOUT_W)) timeout_reg <= 1'b1;
    end
  end

  assign tcb_rdt   = rdt_reg;
  assign tcb_err   = err_reg;
  assign halt      = (state_reg == ST_HALT);
  assign exit_code = exit_code_reg;
  assign timeout   = timeout_reg;

  logic unused_fn3;
  assign unused_fn3 = tcb_fn3[2];

`ifdef HTIF_CONSOLE_EN
  logic fifo_full, fifo_empty;

  assign tcb_rdy = ~(con_req & fifo_full);
  assign con_vld = ~fifo_empty;

  tcb_htif_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEP)
  ) u_con_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (commit & is_con_cmd),
    .push_dat (lo_reg[7:0]),
    .pop      (con_rdy),
    .pop_dat  (con_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
`else
  logic unused_con;
  assign unused_con = ^{con_rdy, con_req, 32'(FIFO_DEP)};
  assign tcb_rdy    = 1'b1;
  assign con_vld    = 1'b0;
  assign con_dat    = 8'h00;
`endif

endmodule

// File: tb/tb_tcb_htif_ctl.sv
// Directed bench for tcb_htif_ctl: vector table for decode/readback plus
// hand sequences for exit, console back-pressure, watchdog and reset.
module tb_tcb_htif_ctl;

  localparam logic [31:0] TH_LO = 32'h8000_1000;
  localparam logic [31:0] TH_HI = 32'h8000_1004;
  localparam logic [31:0] FH_LO = 32'h8000_1040;
  localparam logic [31:0] FH_HI = 32'h8000_1044;

  logic        clk = 1'b0;
  logic        rst;
  logic        tcb_vld, tcb_wen;
  logic [31:0] tcb_adr, tcb_wdt;
  logic [2:0]  tcb_fn3;
  logic [31:0] tcb_rdt;
  logic        tcb_err, tcb_rdy, halt, timeout, con_vld, con_rdy;
  logic [30:0] exit_code;
  logic [7:0]  con_dat;

  logic [31:0] t0_rdt;
  logic        t0_err, t0_rdy, t0_halt, t0_timeout, t0_con_vld;
  logic [30:0] t0_exit_code;
  logic [7:0]  t0_con_dat;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] con_q [$];

  always #5 clk = ~clk;

  tcb_htif_ctl #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .tcb_vld(tcb_vld), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr),
    .tcb_fn3(tcb_fn3), .tcb_wdt(tcb_wdt), .tcb_rdt(tcb_rdt), .tcb_err(tcb_err),
    .tcb_rdy(tcb_rdy), .halt(halt), .exit_code(exit_code), .timeout(timeout),
    .con_vld(con_vld), .con_dat(con_dat), .con_rdy(con_rdy)
  );

  tcb_htif_ctl #(.TIMEOUT(0)) dut_nowd (
    .clk(clk), .rst(rst), .tcb_vld(tcb_vld), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr),
    .tcb_fn3(tcb_fn3), .tcb_wdt(tcb_wdt), .tcb_rdt(t0_rdt), .tcb_err(t0_err),
    .tcb_rdy(t0_rdy), .halt(t0_halt), .exit_code(t0_exit_code), .timeout(t0_timeout),
    .con_vld(t0_con_vld), .con_dat(t0_con_dat), .con_rdy(con_rdy)
  );

  always @(posedge clk) begin
    if (!rst && con_vld && con_rdy) con_q.push_back(con_dat);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_start(input logic wen, input logic [31:0] adr,
                           input logic [2:0] fn3, input logic [31:0] wdt);
    tcb_vld = 1'b1;
    tcb_wen = wen;
    tcb_adr = adr;
    tcb_fn3 = fn3;
    tcb_wdt = wdt;
  endtask

  task automatic bus_finish();
    int budget = 200;
    while (!tcb_rdy && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check("bus_rdy", 32'(tcb_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    tcb_vld = 1'b0;
    tcb_wen = 1'b0;
    $display("txn wen=%0d adr=%h fn3=%0d wdt=%h -> rdt=%h err=%0d",
             tcb_wen, tcb_adr, tcb_fn3, tcb_wdt, tcb_rdt, tcb_err);
  endtask

  task automatic bus(input logic wen, input logic [31:0] adr,
                     input logic [2:0] fn3, input logic [31:0] wdt);
    bus_start(wen, adr, fn3, wdt);
    #1;
    bus_finish();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdt"},     tcb_rdt, 32'h0);
    check({tag, "_err"},     32'(tcb_err), 32'd0);
    check({tag, "_halt"},    32'(halt), 32'd0);
    check({tag, "_exit"},    32'(exit_code), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_con_vld"}, 32'(con_vld), 32'd0);
    check({tag, "_con_dat"}, 32'(con_dat), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        wen;
    logic [31:0] adr;
    logic [2:0]  fn3;
    logic [31:0] wdt;
    logic        chk_rdt;
    logic [31:0] exp_rdt;
    logic        exp_err;
  } vec_t;

  vec_t vecs [17];

  initial begin
    vecs[0]  = '{"wr_th_lo",      1'b1, TH_LO,           3'd2, 32'h1234_5678, 1'b0, 32'h0,          1'b0};
    vecs[1]  = '{"rd_th_lo",      1'b0, TH_LO,           3'd2, 32'h0,         1'b1, 32'h1234_5678,  1'b0};
    vecs[2]  = '{"byte_wr_th_lo", 1'b1, TH_LO,           3'd0, 32'h0000_00ff, 1'b1, 32'h0,          1'b1};
    vecs[3]  = '{"rd_th_lo_kept", 1'b0, TH_LO,           3'd2, 32'h0,         1'b1, 32'h1234_5678,  1'b0};
    vecs[4]  = '{"rd_th_plus8",   1'b0, TH_LO + 32'd8,   3'd2, 32'h0,         1'b1, 32'h0,          1'b1};
    vecs[5]  = '{"rd_misalign",   1'b0, TH_LO + 32'd1,   3'd2, 32'h0,         1'b1, 32'h0,          1'b1};
    vecs[6]  = '{"wr_th_hi_drop", 1'b1, TH_HI,           3'd2, 32'h0200_0000, 1'b0, 32'h0,          1'b0};
    vecs[7]  = '{"half_rd_th_hi", 1'b0, TH_HI,           3'd1, 32'h0,         1'b1, 32'h0,          1'b1};
    vecs[8]  = '{"rd_th_hi",      1'b0, TH_HI,           3'd2, 32'h0,         1'b1, 32'h0200_0000,  1'b0};
    vecs[9]  = '{"wr_fh_lo",      1'b1, FH_LO,           3'd2, 32'hAABB_CCDD, 1'b0, 32'h0,          1'b0};
    vecs[10] = '{"rd_fh_lo",      1'b0, FH_LO,           3'd2, 32'h0,         1'b1, 32'hAABB_CCDD,  1'b0};
    vecs[11] = '{"wr_fh_hi",      1'b1, FH_HI,           3'd2, 32'h1122_3344, 1'b0, 32'h0,          1'b0};
    vecs[12] = '{"rd_fh_hi",      1'b0, FH_HI,           3'd2, 32'h0,         1'b1, 32'h1122_3344,  1'b0};
    vecs[13] = '{"wr_putc_lo",    1'b1, TH_LO,           3'd2, 32'h0000_002A, 1'b0, 32'h0,          1'b0};
    vecs[14] = '{"wr_putc_hi",    1'b1, TH_HI,           3'd2, 32'h0101_0000, 1'b0, 32'h0,          1'b0};
    vecs[15] = '{"rd_fh_lo_ack",  1'b0, FH_LO,           3'd2, 32'h0,         1'b1, 32'h0,          1'b0};
    vecs[16] = '{"rd_fh_hi_ack",  1'b0, FH_HI,           3'd2, 32'h0,         1'b1, 32'h0101_0000,  1'b0};

    rst = 1'b1;
    tcb_vld = 1'b0; tcb_wen = 1'b0; tcb_adr = '0; tcb_fn3 = '0; tcb_wdt = '0;
    con_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_rdy", 32'(tcb_rdy), 32'd1);

    // watchdog: released on a negedge, count rising edges
    rst = 1'b0;
    repeat (99) @(negedge clk);
    check("wdog_at_99", 32'(timeout), 32'd0);
    @(negedge clk);
    check("wdog_at_100", 32'(timeout), 32'd1);
    check("wdog_off", 32'(t0_timeout), 32'd0);

    for (int i = 0; i < 17; i++) begin
      bus(vecs[i].wen, vecs[i].adr, vecs[i].fn3, vecs[i].wdt);
      check({vecs[i].name, "_err"}, 32'(tcb_err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rdt) check({vecs[i].name, "_rdt"}, tcb_rdt, vecs[i].exp_rdt);
    end
    check("putc_no_halt", 32'(halt), 32'd0);

`ifdef HTIF_CONSOLE_EN
    con_q.delete();
    con_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus(1'b1, TH_LO, 3'd2, 32'(8'h41 + i));
      bus(1'b1, TH_HI, 3'd2, 32'h0101_0000);
    end
    bus(1'b1, TH_LO, 3'd2, 32'h0000_0049);
    bus_start(1'b1, TH_HI, 3'd2, 32'h0101_0000);
    #1;
    check("stall_rdy", 32'(tcb_rdy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("stall_rdy_held", 32'(tcb_rdy), 32'd0);
    check("stall_con_vld", 32'(con_vld), 32'd1);
    check("stall_con_dat", 32'(con_dat), 32'h41);
    con_rdy = 1'b1;
    bus_finish();
    for (int b = 0; b < 40 && con_q.size() < 9; b++) @(negedge clk);
    check("con_count", 32'(con_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < con_q.size(); i++) begin
      check($sformatf("con_byte%0d", i), 32'(con_q[i]), 32'(8'h41 + i));
    end
    check("con_drained", 32'(con_vld), 32'd0);
`else
    check("nocon_vld", 32'(con_vld), 32'd0);
    check("nocon_dat", 32'(con_dat), 32'd0);
`endif

    // failing exit, then stickiness
    bus(1'b1, TH_LO, 3'd2, 32'h0000_0007);
    check("exit_pre_halt", 32'(halt), 32'd0);
    bus(1'b1, TH_HI, 3'd2, 32'h0000_0000);
    check("exit7_halt", 32'(halt), 32'd1);
    check("exit7_code", 32'(exit_code), 32'd3);
    bus(1'b1, TH_LO, 3'd2, 32'h0000_0001);
    bus(1'b1, TH_HI, 3'd2, 32'h0000_0000);
    check("sticky_halt", 32'(halt), 32'd1);
    check("sticky_code", 32'(exit_code), 32'd3);
    bus(1'b0, TH_LO, 3'd2, 32'h0);
    check("halt_stores_lo", tcb_rdt, 32'h0000_0001);

    // TH_HI in IDLE must not commit; then a clean exit 0
    do_reset();
    @(negedge clk);
    check_reset_outputs("reset2");
    bus(1'b1, TH_LO, 3'd2, 32'h0000_0001);
    bus(1'b1, TH_HI, 3'd2, 32'h0200_0000);
    bus(1'b1, TH_HI, 3'd2, 32'h0000_0000);
    check("idle_hi_no_commit", 32'(halt), 32'd0);
    bus(1'b1, TH_LO, 3'd2, 32'h0000_0001);
    bus(1'b1, TH_HI, 3'd2, 32'h0000_0000);
    check("exit0_halt", 32'(halt), 32'd1);
    check("exit0_code", 32'(exit_code), 32'd0);

`ifdef HTIF_CONSOLE_EN
    do_reset();
    con_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus(1'b1, TH_LO, 3'd2, 32'(8'h61 + i));
      bus(1'b1, TH_HI, 3'd2, 32'h0101_0000);
    end
    bus(1'b1, TH_LO, 3'd2, 32'h0000_0050);
    bus_start(1'b1, TH_HI, 3'd2, 32'h0101_0000);
    #1;
    check("rst_stall_rdy", 32'(tcb_rdy), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_stall");
    tcb_vld = 1'b0;
    tcb_wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    con_q.delete();
    con_rdy = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_fifo_empty", 32'(con_q.size()), 32'd0);
    check("rst_con_vld", 32'(con_vld), 32'd0);
`endif

    repeat (120) @(negedge clk);
    check("wdog_final", 32'(timeout), 32'd1);
    check("wdog_off_final", 32'(t0_timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tcb_htif_ctl.md
# tcb_htif_ctl

HTIF host-interface controller that sits directly downstream of the R5P Mouse TCB system bus, alongside system memory, as a bus subordinate. It decodes the 64-bit `tohost`/`fromhost` mailbox as two 32-bit words and turns exit commands into a sticky halt with exit code. Console putchar commands go to a buffered byte stream. A cycle watchdog flags runaway programs, so simulation and FPGA builds share one synthesizable halt/console path.

## Interface
- `XLEN`, 32: bus address/data width; only 32 supported.
- `ADR_TOHOST`, 32'h8000_1000: byte address of the `tohost` low word; the high word is at +4.
- `ADR_FROMHOST`, 32'h8000_1040: byte address of the `fromhost` low word; the high word is at +4.
- `FIFO_DEP`, 8: console FIFO depth; power of two, at least 2.
- `TIMEOUT`, 20000: watchdog limit in cycles after reset release; 0 disables the watchdog.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tcb_vld`  in  1  request valid.
- `tcb_wen`  in  1  write enable.
- `tcb_adr`  in  XLEN  byte address.
- `tcb_fn3`  in  3  {unsigned, size}; size 2'd2 means word.
- `tcb_wdt`  in  XLEN  write data.
- `tcb_rdt`  out  XLEN  read data, valid one cycle after transfer.
- `tcb_err`  out  1  error response, valid one cycle after transfer.
- `tcb_rdy`  out  1  ready; a transfer occurs when `tcb_vld & tcb_rdy`.
- `halt`  out  1  sticky: an exit command was committed.
- `exit_code`  out  31  exit code of the committed exit command.
- `timeout`  out  1  sticky: the watchdog expired.
- `con_vld`  out  1  console byte valid.
- `con_dat`  out  8  console byte.
- `con_rdy`  in  1  console consumer ready; a byte is popped when `con_vld & con_rdy`.

## Operation
- Decode uses full-width address compare. Four word addresses are HTIF: TH_LO, TH_HI, FH_LO, FH_HI.
- Any access to a non-HTIF address, or a non-word or misaligned access to an HTIF address, is accepted with `tcb_err`=1 and `tcb_rdt`=0. It causes no state change.
- Registers: `lo`, `hi` (the tohost words) and `fh` (fromhost, 64 bits).
- Writes:
  - A TH_LO write latches `lo`.
  - A TH_HI write latches `hi`.
  - FH_LO/FH_HI writes update the corresponding `fh` half.
- Reads return the stored register and `tcb_err`=0.
- State machine:
  - IDLE: a TH_LO write moves to LOW.
  - LOW: a TH_HI write commits the 64-bit command {wdt, lo}, then moves to IDLE, or to HALT for an exit command.
  - IDLE: a TH_HI write only latches `hi`; there is no commit.
  - HALT: sticky until reset. Writes are accepted and stored but never commit.
- Commit decode, with dev=wdt[31:24], cmd=wdt[23:16]:
  - dev=0 and lo[0]=1: `halt`←1, `exit_code`←lo[31:1].
  - dev=1 and cmd=1: push lo[7:0] into the console FIFO, and set `fh`←{32'h0101_0000, 32'h0}.
  - Any other command: accepted and dropped.
- Watchdog:
  - A 32-bit counter increments every cycle after reset.
  - `timeout`←1 when the count reaches `TIMEOUT` (nonzero only).
  - The counter saturates once `timeout` is set.
- Simultaneous events: halt and timeout can set in the same cycle, and both assert.

## Timing
- DLY=1: `tcb_rdt`/`tcb_err` are registered and valid in the cycle after the transfer. Their value is held otherwise.
- `tcb_rdy` is 1 except when the current request is a committing console write and the FIFO is full (registered full flag). There is no same-cycle pop bypass.
- The CPU must hold its request while `tcb_rdy`=0.
- `halt` is asserted in the cycle after the committing transfer.
- A console byte appears on `con_vld` in the cycle after its push (no FIFO fall-through).
- Reset values: `tcb_rdt`=0, `tcb_err`=0, `halt`=0, `exit_code`=0, `timeout`=0, `con_vld`=0, `con_dat`=0, FIFO empty, state IDLE, `lo`/`hi`/`fh`=0, counter=0.
- Reset mid-operation (including a stalled console push) discards all state; the pending push is lost.
- FIFO pointers wrap modulo `FIFO_DEP`, with an extra wrap bit to separate full from empty.

## Configuration
- `HTIF_CONSOLE_EN` defined: the FIFO and `con_*` path are built as described above.
- Not defined: console commits are accepted, set `fh`, and drop the byte. `tcb_rdy` is constant 1. `con_vld`=0 and `con_dat`=0. No FIFO is instantiated.

## Structure
- Package `tcb_htif_pkg` holds:
  - the state enum (IDLE, LOW, HALT);
  - HTIF constants: device 0/1 and command 1;
  - the word-address offset localparams.
- Sub-module `tcb_htif_fifo` is a synchronous FIFO (push/pop/full/empty), parameterized by width and depth, and instantiated under `HTIF_CONSOLE_EN`.

## Test plan
- Exit: write TH_LO=32'h0000_0001, then TH_HI=0 → `halt`=1 in the next cycle, `exit_code`=0. Later writes leave `halt` and `exit_code` unchanged.
- Failing exit: write TH_LO=32'h0000_0007, then TH_HI=0 → `halt`=1, `exit_code`=3.
- Console: `con_rdy`=0, then 9 commit pairs with TH_LO=8'h41+i and TH_HI=32'h0101_0000 (`FIFO_DEP`=8) → the 9th TH_HI write sees `tcb_rdy`=0. Raise `con_rdy` → bytes 'A'…'I' are popped in order and the 9th write completes.
- Readback and error: a FH_LO read after a console commit returns 0 and FH_HI returns 32'h0101_0000, both with `tcb_err`=0 one cycle later. A read at ADR_TOHOST+8 → `tcb_err`=1. A byte write to TH_LO → `tcb_err`=1 and `lo` is unchanged.
- Watchdog: with `TIMEOUT`=100 and no exit, `timeout` rises exactly 100 cycles after reset release. With `TIMEOUT`=0 it never rises.
- Reset mid-stall: assert `rst` while a console write is stalled → all outputs return to reset values and the FIFO is empty.
